enemy_ai_sched: RTL and testbench



---
 rtl/enemy_ai_sched.sv | 183 ++++++++++++++++++
 tb/tb_enemy_ai_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_ai_sched.sv
// enemy_ai_sched: frame-paced enemy action picker (dodge / shoot / chase / wander).
// Latency: tick -> S_DECIDE after 1 edge, command visible after the 2nd edge.
// No backpressure: commands are held or pulsed, then a cooldown, all paced by i_tick.
module enemy_ai_sched #(
  parameter int         ATTACK_RANGE    = 320,
  parameter int         DODGE_RANGE     = 96,
  parameter int         HOLD_FRAMES     = 8,
  parameter int         COOLDOWN_FRAMES = 4,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_is_gaming,
  input  logic               i_tick,
  input  logic signed [10:0] i_player_x,
  input  logic signed [10:0] i_enemy_x,
  input  logic signed [10:0] i_goodbullet_x,
  input  logic               i_goodbullet_isE,
  input  logic               i_badbullet_isE,
  input  logic               i_enemy_isJ,
  output logic               o_right,
  output logic               o_left,
  output logic               o_jump,
  output logic               o_squat,
  output logic               o_attack,
  output logic               o_defend,
  output logic               o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_ACT, S_COOL} state_t;
  typedef enum logic [2:0] {A_NONE, A_LEFT, A_RIGHT, A_JUMP, A_SQUAT, A_ATTACK, A_DEFEND} act_t;

  localparam logic [11:0] ATK_LIM   = 12'(ATTACK_RANGE);
  localparam logic [11:0] DODGE_LIM = 12'(DODGE_RANGE);
  localparam logic [3:0]  HOLD_LAST = 4'(HOLD_FRAMES - 1);
  localparam logic [3:0]  COOL_LAST = 4'(COOLDOWN_FRAMES - 1);

  state_t      state, state_nxt;
  act_t        act, act_nxt, pick;
  logic [3:0]  cnt, cnt_nxt;
  logic [5:0]  cmd, cmd_nxt;          // {right, left, jump, squat, attack, defend}
  logic        busy_nxt;
  logic [7:0]  lfsr;
  logic [11:0] diff_p, diff_gb, dist_p, dist_gb;
  logic        threat, player_right, act_level, act_breakable;

  // Sign-extend to 12 bits so the difference of two 11-bit positions never overflows.
  assign diff_p       = {i_player_x[10], i_player_x} - {i_enemy_x[10], i_enemy_x};
  assign diff_gb      = {i_goodbullet_x[10], i_goodbullet_x} - {i_enemy_x[10], i_enemy_x};
  assign dist_p       = diff_p[11]  ? (~diff_p + 12'd1)  : diff_p;
  assign dist_gb      = diff_gb[11] ? (~diff_gb + 12'd1) : diff_gb;
  assign threat       = i_goodbullet_isE && (dist_gb <= DODGE_LIM);
  assign player_right = i_player_x > i_enemy_x;

  assign act_level     = (act == A_LEFT) || (act == A_RIGHT) || (act == A_SQUAT) || (act == A_DEFEND);
  assign act_breakable = (act == A_LEFT) || (act == A_RIGHT) || (act == A_SQUAT);

  function automatic logic [5:0] cmd_of(act_t a);
    logic [5:0] c;
    c = '0;
    case (a)
      A_RIGHT:  c = 6'b100000;
      A_LEFT:   c = 6'b010000;
      A_JUMP:   c = 6'b001000;
      A_SQUAT:  c = 6'b000100;
      A_ATTACK: c = 6'b000010;
      A_DEFEND: c = 6'b000001;
      default:  c = 6'b000000;
    endcase
    return c;
  endfunction

  // Action choice: threat, then shoot, then chase, then LFSR-driven wander.
  always_comb begin
    pick = A_NONE;
    if (threat) begin
      pick = (!i_enemy_isJ && lfsr[0]) ? A_JUMP : A_DEFEND;
    end else if (!i_badbullet_isE && (dist_p <= ATK_LIM)) begin
      pick = A_ATTACK;
    end else if (dist_p > ATK_LIM) begin
      pick = player_right ? A_RIGHT : A_LEFT;
    end else begin
      case (lfsr[2:1])
        2'b00:   pick = A_LEFT;
        2'b01:   pick = A_RIGHT;
        2'b10:   pick = A_SQUAT;
        default: pick = A_NONE;
      endcase
    end
  end

  // Next state, tick counter and command; leaving PLAY overrides everything.
  always_comb begin
    state_nxt = state;
    act_nxt   = act;
    cnt_nxt   = cnt;
    cmd_nxt   = cmd;
    case (state)
      S_IDLE: begin
        if (i_tick) begin
          state_nxt = S_DECIDE;
          cnt_nxt   = '0;
        end
      end
      S_DECIDE: begin
        act_nxt   = pick;
        cmd_nxt   = cmd_of(pick);
        state_nxt = S_ACT;
        cnt_nxt   = '0;
      end
      S_ACT: begin
        if (act_breakable && threat) begin
          state_nxt = S_DECIDE;
          cmd_nxt   = '0;
          cnt_nxt   = '0;
        end else if (act_level) begin
          if (i_tick) begin
            if (cnt == HOLD_LAST) begin
              state_nxt = S_COOL;
              cmd_nxt   = '0;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end
        end else begin
          // Pulse actions and NONE occupy exactly one cycle.
          state_nxt = S_COOL;
          cmd_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      default: begin
        cmd_nxt = '0;
        if (i_tick) begin
          if (cnt == COOL_LAST) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
    endcase
    if (!i_is_gaming) begin
      state_nxt = S_IDLE;
      cmd_nxt   = '0;
      cnt_nxt   = '0;
    end
    busy_nxt = (state_nxt != S_IDLE);
  end

  // Scheduler registers; outputs are registered so they drop on async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      act    <= A_NONE;
      cnt    <= '0;
      cmd    <= '0;
      o_busy <= 1'b0;
    end else begin
      state  <= state_nxt;
      act    <= act_nxt;
      cnt    <= cnt_nxt;
      cmd    <= cmd_nxt;
      o_busy <= busy_nxt;
    end
  end

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, runs only during play, escapes the all-zero lockup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (lfsr == 8'h00) begin
      lfsr <= 8'h01;
    end else if (i_is_gaming) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign {o_right, o_left, o_jump, o_squat, o_attack, o_defend} = cmd;

endmodule

// File: tb/tb_enemy_ai_sched.sv
// tb_enemy_ai_sched: scenario and randomized checks of enemy_ai_sched against a behavioural model.
// Inputs are driven on the falling edge and outputs sampled on the falling edge.
// Every comparison steps n_cmp; every mismatch steps n_bad and prints one FAIL line.
module tb_enemy_ai_sched;
  localparam int         HOLD = 8;
  localparam int         COOL = 4;
  localparam int         ATK  = 320;
  localparam int         DOD  = 96;
  localparam logic [7:0] SEED = 8'hA5;
  localparam int A_NONE = 0, A_LEFT = 1, A_RIGHT = 2, A_JUMP = 3, A_SQUAT = 4, A_ATTACK = 5, A_DEFEND = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_is_gaming = 1'b0, i_tick = 1'b0;
  logic signed [10:0] i_player_x = '0, i_enemy_x = '0, i_goodbullet_x = '0;
  logic i_goodbullet_isE = 1'b0, i_badbullet_isE = 1'b0, i_enemy_isJ = 1'b0;
  logic o_right, o_left, o_jump, o_squat, o_attack, o_defend, o_busy;
  wire [5:0] obs = {o_right, o_left, o_jump, o_squat, o_attack, o_defend};

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] m_lfsr = SEED;
  logic [7:0] pre_lfsr = SEED;

  enemy_ai_sched dut (
    .clk(clk), .rst_n(rst_n), .i_is_gaming(i_is_gaming), .i_tick(i_tick),
    .i_player_x(i_player_x), .i_enemy_x(i_enemy_x), .i_goodbullet_x(i_goodbullet_x),
    .i_goodbullet_isE(i_goodbullet_isE), .i_badbullet_isE(i_badbullet_isE), .i_enemy_isJ(i_enemy_isJ),
    .o_right(o_right), .o_left(o_left), .o_jump(o_jump), .o_squat(o_squat),
    .o_attack(o_attack), .o_defend(o_defend), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(logic [7:0] l);
    if (l == 8'h00) return 8'h01;
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic int model_act(int p, int e, int g, bit ge, bit be, bit j, logic [7:0] l);
    int dp;
    int dg;
    dp = (p > e) ? p - e : e - p;
    dg = (g > e) ? g - e : e - g;
    if (ge && dg <= DOD) return (!j && l[0]) ? A_JUMP : A_DEFEND;
    if (!be && dp <= ATK) return A_ATTACK;
    if (dp > ATK) return (p > e) ? A_RIGHT : A_LEFT;
    case (l[2:1])
      2'd0: return A_LEFT;
      2'd1: return A_RIGHT;
      2'd2: return A_SQUAT;
      default: return A_NONE;
    endcase
  endfunction

  function automatic logic [5:0] cmd_of(int a);
    case (a)
      A_RIGHT:  return 6'b100000;
      A_LEFT:   return 6'b010000;
      A_JUMP:   return 6'b001000;
      A_SQUAT:  return 6'b000100;
      A_ATTACK: return 6'b000010;
      A_DEFEND: return 6'b000001;
      default:  return 6'b000000;
    endcase
  endfunction

  function automatic bit is_level(int a);
    return (a == A_LEFT) || (a == A_RIGHT) || (a == A_SQUAT) || (a == A_DEFEND);
  endfunction

  // One clock: the model LFSR follows the edge, then we land on the falling edge.
  task automatic cyc();
    @(posedge clk);
    pre_lfsr = m_lfsr;
    if (!rst_n) m_lfsr = SEED;
    else if (i_is_gaming) m_lfsr = lfsr_step(m_lfsr);
    @(negedge clk);
  endtask

  // Tick from idle and let the decision edge happen; returns the model's action.
  task automatic start_decide(input string tag, input bit tick2, output int a);
    i_tick = 1'b1;
    cyc();
    i_tick = tick2;
    n_cmp++;
    if (o_busy !== 1'b1 || obs !== 6'b0) begin
      n_bad++;
      $display("FAIL %s_decide: busy=%b cmd=%b want busy=1 cmd=000000", tag, o_busy, obs);
    end
    cyc();
    i_tick = 1'b0;
    a = model_act(int'(i_player_x), int'(i_enemy_x), int'(i_goodbullet_x),
                  i_goodbullet_isE, i_badbullet_isE, i_enemy_isJ, pre_lfsr);
    i_goodbullet_isE = 1'b0;
    n_cmp++;
    if (obs !== cmd_of(a) || o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_act: cmd=%b busy=%b want cmd=%b busy=1", tag, obs, o_busy, cmd_of(a));
    end
  endtask

  // From the first S_ACT cycle: hold or pulse, then cooldown, then idle.
  task automatic play_action(input string tag, input int a);
    if (is_level(a)) begin
      for (int t = 1; t <= HOLD; t++) begin
        repeat ($urandom_range(0, 2)) begin
          cyc();
          n_cmp++;
          if (obs !== cmd_of(a)) begin
            n_bad++;
            $display("FAIL %s_hold_gap: cmd=%b want %b (tick %0d)", tag, obs, cmd_of(a), t);
          end
        end
        i_tick = 1'b1;
        cyc();
        i_tick = 1'b0;
        n_cmp++;
        if (obs !== ((t == HOLD) ? 6'b0 : cmd_of(a)) || o_busy !== 1'b1) begin
          n_bad++;
          $display("FAIL %s_hold_tick%0d: cmd=%b busy=%b want cmd=%b busy=1", tag, t, obs, o_busy,
                   (t == HOLD) ? 6'b0 : cmd_of(a));
        end
      end
    end else begin
      cyc();
      n_cmp++;
      if (obs !== 6'b0 || o_busy !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_pulse_end: cmd=%b busy=%b want cmd=000000 busy=1", tag, obs, o_busy);
      end
    end
    for (int t = 1; t <= COOL; t++) begin
      repeat ($urandom_range(0, 2)) begin
        cyc();
        n_cmp++;
        if (obs !== 6'b0 || o_busy !== 1'b1) begin
          n_bad++;
          $display("FAIL %s_cool_gap: cmd=%b busy=%b want cmd=000000 busy=1", tag, obs, o_busy);
        end
      end
      i_tick = 1'b1;
      cyc();
      i_tick = 1'b0;
      n_cmp++;
      if (obs !== 6'b0 || o_busy !== (t != COOL)) begin
        n_bad++;
        $display("FAIL %s_cool_tick%0d: cmd=%b busy=%b want cmd=000000 busy=%b", tag, t, obs, o_busy, t != COOL);
      end
    end
  endtask

  task automatic set_pos(input int p, input int e, input int g, input bit ge, input bit be, input bit j);
    i_player_x = 11'(p);
    i_enemy_x = 11'(e);
    i_goodbullet_x = 11'(g);
    i_goodbullet_isE = ge;
    i_badbullet_isE = be;
    i_enemy_isJ = j;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_is_gaming = 1'b0;
    m_lfsr = SEED;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs !== 6'b0 || o_busy !== 1'b0 || dut.lfsr !== SEED) begin
      n_bad++;
      $display("FAIL reset_state: cmd=%b busy=%b lfsr=%h want 000000 0 %h", obs, o_busy, dut.lfsr, SEED);
    end
    rst_n = 1'b1;
    i_is_gaming = 1'b1;
    cyc();
    n_cmp++;
    if (dut.lfsr !== m_lfsr || dut.lfsr === SEED) begin
      n_bad++;
      $display("FAIL reset_lfsr_first: lfsr=%h want %h", dut.lfsr, m_lfsr);
    end
    repeat (12) begin
      cyc();
      n_cmp++;
      if (obs !== 6'b0 || o_busy !== 1'b0 || dut.lfsr !== m_lfsr) begin
        n_bad++;
        $display("FAIL reset_idle: cmd=%b busy=%b lfsr=%h want 000000 0 %h", obs, o_busy, dut.lfsr, m_lfsr);
      end
    end
  endtask

  task automatic test_chase();
    int a;
    set_pos(600, 100, 0, 1'b0, 1'b0, 1'b0);
    start_decide("chase", 1'b0, a);
    n_cmp++;
    if (o_right !== 1'b1) begin
      n_bad++;
      $display("FAIL chase_right: o_right=%b want 1", o_right);
    end
    play_action("chase", a);
  endtask

  task automatic test_shoot();
    int a;
    set_pos(300, 100, 0, 1'b0, 1'b0, 1'b0);
    start_decide("shoot", 1'b0, a);
    n_cmp++;
    if (o_attack !== 1'b1) begin
      n_bad++;
      $display("FAIL shoot_attack: o_attack=%b want 1", o_attack);
    end
    play_action("shoot", a);
    set_pos(300, 100, 0, 1'b0, 1'b1, 1'b0);
    start_decide("wander", 1'b0, a);
    play_action("wander", a);
  endtask

  task automatic test_dodge();
    int a;
    set_pos(300, 100, 150, 1'b1, 1'b0, 1'b1);
    start_decide("dodge", 1'b0, a);
    n_cmp++;
    if (o_defend !== 1'b1 || o_jump !== 1'b0) begin
      n_bad++;
      $display("FAIL dodge_defend: defend=%b jump=%b want 1 0", o_defend, o_jump);
    end
    play_action("dodge", a);
  endtask

  task automatic test_preempt();
    int a;
    set_pos(0, 500, 0, 1'b0, 1'b0, 1'b1);
    start_decide("preempt", 1'b0, a);
    repeat (2) cyc();
    n_cmp++;
    if (o_left !== 1'b1) begin
      n_bad++;
      $display("FAIL preempt_left_held: o_left=%b want 1", o_left);
    end
    i_goodbullet_x = 11'sd520;
    i_goodbullet_isE = 1'b1;
    cyc();
    n_cmp++;
    if (obs !== 6'b0 || o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL preempt_clear: cmd=%b busy=%b want 000000 1", obs, o_busy);
    end
    cyc();
    a = model_act(int'(i_player_x), int'(i_enemy_x), int'(i_goodbullet_x),
                  i_goodbullet_isE, i_badbullet_isE, i_enemy_isJ, pre_lfsr);
    i_goodbullet_isE = 1'b0;
    n_cmp++;
    if (obs !== cmd_of(a) || o_defend !== 1'b1) begin
      n_bad++;
      $display("FAIL preempt_defend: cmd=%b want %b", obs, cmd_of(a));
    end
    play_action("preempt", a);
  endtask

  task automatic test_stop();
    int a;
    set_pos(600, 100, 0, 1'b0, 1'b0, 1'b0);
    start_decide("stop", 1'b0, a);
    i_tick = 1'b1;
    cyc();
    i_tick = 1'b0;
    i_is_gaming = 1'b0;
    cyc();
    n_cmp++;
    if (obs !== 6'b0 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_abort: cmd=%b busy=%b want 000000 0", obs, o_busy);
    end
    repeat (3) cyc();
    n_cmp++;
    if (dut.lfsr !== m_lfsr || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_lfsr_hold: lfsr=%h busy=%b want %h 0", dut.lfsr, o_busy, m_lfsr);
    end
    // Game resumes on the same cycle as a tick: that tick must be taken.
    i_is_gaming = 1'b1;
    start_decide("resume", 1'b0, a);
    play_action("resume", a);
  endtask

  task automatic test_reset_mid();
    int a;
    set_pos(0, 500, 0, 1'b0, 1'b0, 1'b0);
    start_decide("rstmid", 1'b0, a);
    cyc();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 6'b0 || o_busy !== 1'b0 || dut.lfsr !== SEED) begin
      n_bad++;
      $display("FAIL rstmid_async: cmd=%b busy=%b lfsr=%h want 000000 0 %h", obs, o_busy, dut.lfsr, SEED);
    end
    m_lfsr = SEED;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    n_cmp++;
    if (obs !== 6'b0 || o_busy !== 1'b0 || dut.lfsr !== m_lfsr) begin
      n_bad++;
      $display("FAIL rstmid_after: cmd=%b busy=%b lfsr=%h want 000000 0 %h", obs, o_busy, dut.lfsr, m_lfsr);
    end
  endtask

  task automatic test_random();
    int a;
    int e;
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 3)) begin
        cyc();
        n_cmp++;
        if (obs !== 6'b0 || o_busy !== 1'b0) begin
          n_bad++;
          $display("FAIL rand_idle: cmd=%b busy=%b want 000000 0 (iter %0d)", obs, o_busy, it);
        end
      end
      e = int'($urandom_range(0, 800)) - 400;
      set_pos(e + int'($urandom_range(0, 800)) - 400, e, e + int'($urandom_range(0, 300)) - 150,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      start_decide("rand", 1'($urandom_range(0, 1)), a);
      play_action("rand", a);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_chase();
    test_shoot();
    test_dodge();
    test_preempt();
    test_stop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
